// File: rtl/safe_sync_pkg.sv
// Shared types for the dual-lockstep entry initiator.
//   sync_init_e     : initiator FSM states
//   DEFAULT_TIMEOUT : default wait-state cycle budget
package safe_sync_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ_HALT,
    WAIT_ACK,
    SYNC2,
    WAIT_SYNC_IRQ,
    DUAL,
    ERROR
  } sync_init_e;

  localparam int DEFAULT_TIMEOUT = 1000;

endpackage

// File: rtl/safe_sync_initiator_if.sv
// Handshake bundle between the CSR/interrupt side, the cores, the safety FSM
// and the initiator.
//   master : drives requests, acks and interrupts; observes sync outputs
//   slave  : the initiator itself
interface safe_sync_initiator_if;
  logic       start_i;
  logic       exit_i;
  logic [1:0] core_ack_i;
  logic       Interrupt_Halt;
  logic       Interrupt_Sync;
  logic       Sync1;
  logic       Sync2;
  logic       Dual_Sync;
  logic       busy_o;
  logic       timeout_o;

  modport master (
    output start_i, exit_i, core_ack_i, Interrupt_Halt, Interrupt_Sync,
    input  Sync1, Sync2, Dual_Sync, busy_o, timeout_o
  );

  modport slave (
    input  start_i, exit_i, core_ack_i, Interrupt_Halt, Interrupt_Sync,
    output Sync1, Sync2, Dual_Sync, busy_o, timeout_o
  );
endinterface

// File: rtl/safe_sync_timer.sv
// Saturating wait-state timer.
//   clk_i, rst_ni : clock, async active-low reset
//   clear         : load 0 (wins over enable)
//   enable        : count one cycle
//   expired       : count has reached TIMEOUT; tied low when TIMEOUT == 0
module safe_sync_timer #(
  parameter int TIMEOUT   = 1000,
  parameter int TIMEOUT_W = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT);

  logic [TIMEOUT_W-1:0] cnt_q;

  // Stops at LIMIT so the count never wraps back under the threshold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                       cnt_q <= '0;
    else if (clear)                    cnt_q <= '0;
    else if (enable && cnt_q != LIMIT) cnt_q <= cnt_q + TIMEOUT_W'(1);
  end

  assign expired = (TIMEOUT != 0) && (cnt_q == LIMIT);

endmodule

// File: rtl/safe_sync_initiator.sv
// Core-side initiator of the dual-lockstep entry handshake.
//   clk_i, rst_ni : clock, async active-low reset
//   bus (slave)   : start_i/exit_i requests, core_ack_i, Interrupt_Halt,
//                   Interrupt_Sync in; Sync1, Sync2, Dual_Sync, busy_o,
//                   timeout_o out (all registered)
module safe_sync_initiator
  import safe_sync_pkg::*;
#(
  parameter int TIMEOUT   = DEFAULT_TIMEOUT,
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  safe_sync_initiator_if.slave bus
);

  sync_init_e state_q, state_d;
  logic [1:0] ack_q;
  logic       ack_all;
  logic       expired;
  logic       tmr_clear;
  logic       tmr_en;

  // Counts acks already held plus any arriving this cycle.
  assign ack_all = &(ack_q | bus.core_ack_i);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:          if (bus.start_i) state_d = REQ_HALT;
      REQ_HALT: begin
        if (bus.exit_i)              state_d = IDLE;
        else if (bus.Interrupt_Halt) state_d = WAIT_ACK;
        else if (expired)            state_d = ERROR;
      end
      WAIT_ACK: begin
        if (bus.exit_i)   state_d = IDLE;
        else if (ack_all) state_d = SYNC2;
        else if (expired) state_d = ERROR;
      end
      SYNC2:         state_d = WAIT_SYNC_IRQ;
      // Committed from here on: exit_i is not looked at.
      WAIT_SYNC_IRQ: begin
        if (bus.Interrupt_Sync) state_d = DUAL;
        else if (expired)       state_d = ERROR;
      end
      DUAL:          if (bus.exit_i) state_d = IDLE;
      ERROR: begin
        if (bus.start_i)     state_d = REQ_HALT;
        else if (bus.exit_i) state_d = IDLE;
      end
      default:       state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Every state change reloads the timer, so each wait gets a fresh budget.
  assign tmr_clear = (state_d != state_q) || (state_q == IDLE);
  assign tmr_en    = (state_q == REQ_HALT) || (state_q == WAIT_ACK) ||
                     (state_q == WAIT_SYNC_IRQ);

  safe_sync_timer #(
    .TIMEOUT   (TIMEOUT),
    .TIMEOUT_W (TIMEOUT_W)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .expired (expired)
  );

  // Acks only accumulate in WAIT_ACK; early acks are deliberately lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      ack_q <= '0;
    else if ((state_d == IDLE) || (state_d == REQ_HALT && state_q != REQ_HALT))
      ack_q <= '0;
    else if (state_q == WAIT_ACK)
      ack_q <= ack_q | bus.core_ack_i;
  end

  // Outputs are flops of the next-state decode: they track the state register
  // exactly and carry no combinational path from any input.
  logic sync1_q, sync2_q, dual_q, busy_q, tmo_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dual_q  <= 1'b0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      sync1_q <= (state_d == REQ_HALT);
      sync2_q <= (state_d == SYNC2);
      dual_q  <= (state_d == DUAL);
      busy_q  <= (state_d == REQ_HALT) || (state_d == WAIT_ACK) ||
                 (state_d == SYNC2)    || (state_d == WAIT_SYNC_IRQ);
      tmo_q   <= (state_d == ERROR);
    end
  end

  assign bus.Sync1     = sync1_q;
  assign bus.Sync2     = sync2_q;
  assign bus.Dual_Sync = dual_q;
  assign bus.busy_o    = busy_q;
  assign bus.timeout_o = tmo_q;

endmodule

// File: tb/tb_safe_sync_initiator.sv
module tb_safe_sync_initiator;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_i = ~clk_i;

  safe_sync_initiator_if li ();
  safe_sync_initiator_if si ();
  safe_sync_initiator_if zi ();

  safe_sync_initiator #(.TIMEOUT(1000), .TIMEOUT_W(16)) u_l (
    .clk_i(clk_i), .rst_ni(rst_ni), .bus(li));
  safe_sync_initiator #(.TIMEOUT(4), .TIMEOUT_W(16)) u_s (
    .clk_i(clk_i), .rst_ni(rst_ni), .bus(si));
  safe_sync_initiator #(.TIMEOUT(0), .TIMEOUT_W(16)) u_z (
    .clk_i(clk_i), .rst_ni(rst_ni), .bus(zi));

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    li.start_i = 0; li.exit_i = 0; li.core_ack_i = 0; li.Interrupt_Halt = 0; li.Interrupt_Sync = 0;
    si.start_i = 0; si.exit_i = 0; si.core_ack_i = 0; si.Interrupt_Halt = 0; si.Interrupt_Sync = 0;
    zi.start_i = 0; zi.exit_i = 0; zi.core_ack_i = 0; zi.Interrupt_Halt = 0; zi.Interrupt_Sync = 0;

    #12;
    chk("reset_outs", {li.Sync1, li.Sync2, li.Dual_Sync, li.busy_o, li.timeout_o}, 5'b0);
    rst_ni = 1'b1;
    step();

    li.start_i = 1;
    step(); li.start_i = 0;
    chk("hp_sync1_rise", li.Sync1, 1'b1);
    chk("hp_busy_rise", li.busy_o, 1'b1);
    repeat (4) step();
    li.Interrupt_Halt = 1;
    chk("hp_sync1_c5", li.Sync1, 1'b1);
    step(); li.Interrupt_Halt = 0;
    chk("hp_sync1_fall", li.Sync1, 1'b0);
    step(); step();
    li.core_ack_i = 2'b01;
    step(); li.core_ack_i = 2'b00;
    chk("hp_sync2_one_ack", li.Sync2, 1'b0);
    repeat (3) step();
    li.core_ack_i = 2'b10;
    step(); li.core_ack_i = 2'b00;
    chk("hp_sync2_c13", li.Sync2, 1'b1);
    step();
    chk("hp_sync2_c14", li.Sync2, 1'b0);
    chk("hp_busy_c14", li.busy_o, 1'b1);
    li.exit_i = 1;
    step(); li.exit_i = 0;
    chk("hp_exit_ignored", li.busy_o, 1'b1);
    li.Interrupt_Sync = 1;
    step(); li.Interrupt_Sync = 0;
    chk("hp_dual_c16", li.Dual_Sync, 1'b1);
    chk("hp_busy_c16", li.busy_o, 1'b0);
    step();
    li.start_i = 1;
    step(); li.start_i = 0;
    chk("dual_start_ignored", {li.Dual_Sync, li.Sync1, li.busy_o}, 3'b100);
    repeat (12) step();
    li.exit_i = 1;
    step(); li.exit_i = 0;
    chk("hp_exit_outs", {li.Sync1, li.Sync2, li.Dual_Sync, li.busy_o, li.timeout_o}, 5'b0);

    li.start_i = 1;
    step(); li.start_i = 0;
    li.exit_i = 1;
    step(); li.exit_i = 0;
    chk("abort_req_halt", {li.Sync1, li.busy_o}, 2'b00);

    si.start_i = 1;
    step(); si.start_i = 0;
    chk("to_sync1", si.Sync1, 1'b1);
    repeat (4) step();
    chk("to_not_yet", {si.Sync1, si.timeout_o}, 2'b10);
    step();
    chk("to_error", {si.Sync1, si.busy_o, si.timeout_o}, 3'b001);
    si.start_i = 1; si.exit_i = 1;
    step(); si.start_i = 0; si.exit_i = 0;
    chk("retry", {si.Sync1, si.timeout_o}, 2'b10);
    si.core_ack_i = 2'b10;
    step(); si.core_ack_i = 2'b00;
    repeat (3) step();
    si.Interrupt_Halt = 1;
    step(); si.Interrupt_Halt = 0;
    chk("boundary_halt", {si.Sync1, si.busy_o, si.timeout_o}, 3'b010);
    si.core_ack_i = 2'b01;
    step(); si.core_ack_i = 2'b00;
    chk("early_ack_dropped", si.Sync2, 1'b0);
    si.core_ack_i = 2'b10;
    step(); si.core_ack_i = 2'b00;
    chk("late_ack_sync2", si.Sync2, 1'b1);
    step();
    chk("wsi_enter", {si.Sync2, si.busy_o}, 2'b01);
    repeat (4) step();
    chk("wsi_not_yet", {si.busy_o, si.timeout_o}, 2'b10);
    step();
    chk("wsi_timeout", {si.busy_o, si.timeout_o}, 2'b01);
    si.exit_i = 1;
    step(); si.exit_i = 0;
    chk("error_exit", {si.busy_o, si.timeout_o}, 2'b00);

    zi.start_i = 1;
    step(); zi.start_i = 0;
    repeat (5000) step();
    chk("zero_to_stall", {zi.Sync1, zi.busy_o, zi.timeout_o}, 3'b110);
    zi.Interrupt_Halt = 1;
    step(); zi.Interrupt_Halt = 0;
    chk("zero_halt", zi.Sync1, 1'b0);
    zi.core_ack_i = 2'b11;
    step(); zi.core_ack_i = 2'b00;
    chk("simul_ack_sync2", zi.Sync2, 1'b1);
    step();
    chk("simul_sync2_once", zi.Sync2, 1'b0);
    zi.Interrupt_Sync = 1;
    step(); zi.Interrupt_Sync = 0;
    chk("zero_dual", zi.Dual_Sync, 1'b1);

    li.start_i = 1;
    step(); li.start_i = 0;
    li.Interrupt_Halt = 1;
    step(); li.Interrupt_Halt = 0;
    chk("pre_rst_wait_ack", {li.Sync1, li.busy_o}, 2'b01);
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst_li", li.busy_o, 1'b0);
    chk("async_rst_zi", zi.Dual_Sync, 1'b0);
    #1 rst_ni = 1'b1;
    step();
    chk("post_rst_idle", {li.Sync1, li.busy_o, li.timeout_o}, 3'b000);
    li.start_i = 1;
    step(); li.start_i = 0;
    chk("post_rst_start", li.Sync1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
